gpfc_pause_scheduler: RTL and testbench

//  Sequences GPFC pause/resume frame emission for one egress link. Takes (rank, time) events from the

---
 rtl/gpfc_pkg.sv | 31 +++
 rtl/gpfc_reload_counter.sv | 27 ++
 rtl/gpfc_pause_scheduler.sv | 136 +++++++++++++
 tb/tb_gpfc_pause_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpfc_pkg.sv
// Shared GPFC definitions: scheduler FSM states, pause-frame classification codes
// and the default field values the congestion monitor also uses.
package gpfc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } gpfc_state_t;

   typedef enum logic [1:0] {
      GPFC_XON      = 2'd0,
      GPFC_XOFFLOW  = 2'd1,
      GPFC_XOFFALL  = 2'd2
   } gpfc_code_t;

   localparam logic [15:0] PAUSE_RANK_VALUE_ALL     = 16'd0;
   localparam logic [15:0] PAUSE_TIME_VALUE_DEFAULT = 16'hFFFF;

   // Classifies a (rank, time) pair: zero time resumes, rank 0 pauses every rank.
   function automatic gpfc_code_t pause_code(input logic [15:0] rank, input logic [15:0] ptime);
      gpfc_code_t code;
      code = GPFC_XOFFLOW;
      if (ptime == 16'd0)
         code = GPFC_XON;
      else if (rank == PAUSE_RANK_VALUE_ALL)
         code = GPFC_XOFFALL;
      return code;
   endfunction

endpackage

// File: rtl/gpfc_reload_counter.sv
// Down-counter with synchronous load, count enable and zero flag; saturates at zero.
module gpfc_reload_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // NOTE: reset is synchronous here, so rstn is sampled inside the clocked block rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rstn)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (enable && count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/gpfc_pause_scheduler.sv
// GPFC pause/resume frame scheduler for one egress link: coalescing slot, min-gap and refresh.
// Optional statistics outputs are built when GPFC_PAUSE_STATS_EN is defined.
module gpfc_pause_scheduler #(
   parameter int PAUSE_RANK_WIDTH = 16,
   parameter int PAUSE_TIME_WIDTH = 16,
   parameter int GAP_CNT_WIDTH    = 16,
   parameter int MIN_GAP_CYCLES   = 64,
   parameter int REFRESH_CYCLES   = 8192
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        s_pause_valid,
   input  logic [PAUSE_RANK_WIDTH-1:0] s_pause_rank,
   input  logic [PAUSE_TIME_WIDTH-1:0] s_pause_time,
   output logic                        m_frame_valid,
   input  logic                        m_frame_ready,
   output logic [PAUSE_RANK_WIDTH-1:0] m_frame_rank,
   output logic [PAUSE_TIME_WIDTH-1:0] m_frame_time,
   output logic                        m_pause_active
`ifdef GPFC_PAUSE_STATS_EN
   ,
   output logic [31:0]                 stat_frames_sent,
   output logic [31:0]                 stat_coalesced
`endif
);

   import gpfc_pkg::*;

   localparam logic [GAP_CNT_WIDTH-1:0] GAP_LOAD     = GAP_CNT_WIDTH'(MIN_GAP_CYCLES - 1);
   localparam logic [GAP_CNT_WIDTH-1:0] REFRESH_LOAD = GAP_CNT_WIDTH'(REFRESH_CYCLES - 1);

   gpfc_state_t                 state, state_next;
   logic                        pend;
   logic [PAUSE_RANK_WIDTH-1:0] slot_rank;
   logic [PAUSE_TIME_WIDTH-1:0] slot_time;
   logic                        gap_zero;
   logic                        refresh_zero;
   logic                        accept;
   logic                        load_frame;
   logic                        refresh_run;
   logic                        refresh_fire;

   assign m_frame_valid = (state == ST_SEND);
   assign accept        = m_frame_valid && m_frame_ready;
   assign load_frame    = (state == ST_IDLE) && pend;
   assign refresh_run   = m_pause_active && (state != ST_SEND);
   // Re-queue the active pause only into an empty slot; a fresh event always takes precedence.
   assign refresh_fire  = refresh_run && refresh_zero && !pend;

   always_ff @(posedge clk) begin
      if (!rstn)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // NOTE: combinational next-state logic uses blocking assignments and a default first, so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (pend)          state_next = ST_SEND;
         ST_SEND: if (m_frame_ready) state_next = ST_GAP;
         ST_GAP:  if (gap_zero)      state_next = ST_IDLE;
         default:                    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pend           <= 1'b0;
         slot_rank      <= '0;
         slot_time      <= '0;
         m_frame_rank   <= '0;
         m_frame_time   <= '0;
         m_pause_active <= 1'b0;
      end else begin
         if (s_pause_valid) begin
            slot_rank <= s_pause_rank;
            slot_time <= s_pause_time;
            pend      <= 1'b1;
         end else if (refresh_fire) begin
            slot_rank <= m_frame_rank;
            slot_time <= m_frame_time;
            pend      <= 1'b1;
         end else if (load_frame) begin
            pend <= 1'b0;
         end

         if (load_frame) begin
            m_frame_rank <= slot_rank;
            m_frame_time <= slot_time;
         end

         if (accept)
            m_pause_active <= (m_frame_time != '0);
      end
   end

   gpfc_reload_counter #(.WIDTH(GAP_CNT_WIDTH)) u_gap_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .load       (accept),
      .load_value (GAP_LOAD),
      .enable     (state == ST_GAP),
      .zero       (gap_zero)
   );

   gpfc_reload_counter #(.WIDTH(GAP_CNT_WIDTH)) u_refresh_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .load       (accept),
      .load_value (REFRESH_LOAD),
      .enable     (refresh_run),
      .zero       (refresh_zero)
   );

`ifdef GPFC_PAUSE_STATS_EN
   logic coalesce;

   // An event replacing a pending frame that is not being consumed this cycle is a coalesce.
   assign coalesce = s_pause_valid && pend && !load_frame;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stat_frames_sent <= '0;
         stat_coalesced   <= '0;
      end else begin
         if (accept && stat_frames_sent != '1)
            stat_frames_sent <= stat_frames_sent + 32'd1;
         if (coalesce && stat_coalesced != '1)
            stat_coalesced <= stat_coalesced + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gpfc_pause_scheduler.sv
// Scoreboard bench for gpfc_pause_scheduler: directed events push expected frames,
// a monitor pops and compares every accepted frame.
module tb_gpfc_pause_scheduler;

   localparam int MIN_GAP = 64;
   localparam int REFRESH = 200;

   typedef struct packed {
      logic [15:0] rank;
      logic [15:0] tm;
   } frame_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        s_pause_valid = 1'b0;
   logic [15:0] s_pause_rank = '0;
   logic [15:0] s_pause_time = '0;
   logic        m_frame_valid;
   logic        m_frame_ready = 1'b0;
   logic [15:0] m_frame_rank;
   logic [15:0] m_frame_time;
   logic        m_pause_active;
`ifdef GPFC_PAUSE_STATS_EN
   logic [31:0] stat_frames_sent;
   logic [31:0] stat_coalesced;
`endif

   frame_t sb_q[$];
   int     acc_cyc[$];
   int     cyc = 0;
   int     n_cmp = 0;
   int     n_err = 0;
   int     n_pushed = 0;
   int     n_frames = 0;
   int     idx;

   gpfc_pause_scheduler #(
      .PAUSE_RANK_WIDTH (16),
      .PAUSE_TIME_WIDTH (16),
      .GAP_CNT_WIDTH    (16),
      .MIN_GAP_CYCLES   (MIN_GAP),
      .REFRESH_CYCLES   (REFRESH)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .s_pause_valid  (s_pause_valid),
      .s_pause_rank   (s_pause_rank),
      .s_pause_time   (s_pause_time),
      .m_frame_valid  (m_frame_valid),
      .m_frame_ready  (m_frame_ready),
      .m_frame_rank   (m_frame_rank),
      .m_frame_time   (m_frame_time),
      .m_pause_active (m_pause_active)
`ifdef GPFC_PAUSE_STATS_EN
      ,
      .stat_frames_sent (stat_frames_sent),
      .stat_coalesced   (stat_coalesced)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: sampled on the falling edge, so valid&&ready here means acceptance at the next rising edge.
   always @(negedge clk) begin
      if (m_frame_valid && m_frame_ready) begin
         frame_t got;
         got = '{rank: m_frame_rank, tm: m_frame_time};
         n_frames++;
         acc_cyc.push_back(cyc);
         if (sb_q.size() == 0)
            check("unexpected_frame", {32'd1, got}, {32'd0, got});
         else
            check("frame", got, sb_q.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_event(input logic [15:0] r, input logic [15:0] t);
      s_pause_valid = 1'b1;
      s_pause_rank  = r;
      s_pause_time  = t;
      tick(1);
      s_pause_valid = 1'b0;
   endtask

   task automatic expect_frame(input logic [15:0] r, input logic [15:0] t);
      sb_q.push_back('{rank: r, tm: t});
      n_pushed++;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb_q.size() == 0) break;
         tick(1);
      end
      check(name, sb_q.size(), 0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (m_frame_valid) break;
         tick(1);
      end
      check(name, m_frame_valid, 1);
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_valid", m_frame_valid, 0);
      check("rst_rank", m_frame_rank, 0);
      check("rst_time", m_frame_time, 0);
      check("rst_active", m_pause_active, 0);
      rstn = 1'b1;
      tick(2);

      // 1: single XOFF event, two-cycle latency, pause becomes active
      m_frame_ready = 1'b1;
      expect_frame(16'd5, 16'hFFFF);
      send_event(16'd5, 16'hFFFF);
      check("t1_valid_lat1", m_frame_valid, 0);
      tick(1);
      check("t1_valid_lat2", m_frame_valid, 1);
      check("t1_rank", m_frame_rank, 16'd5);
      check("t1_time", m_frame_time, 16'hFFFF);
      tick(1);
      check("t1_active", m_pause_active, 1);
      check("t1_valid_gap", m_frame_valid, 0);

      // 2: backpressure holds the frame; a resume arriving in SEND is sent after the gap
      m_frame_ready = 1'b0;
      expect_frame(16'd9, 16'd1234);
      send_event(16'd9, 16'd1234);
      wait_valid("t2_valid_timeout", 3 * MIN_GAP);
      expect_frame(16'd0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         check("t2_hold_valid", m_frame_valid, 1);
         check("t2_hold_frame", {m_frame_rank, m_frame_time}, {16'd9, 16'd1234});
         s_pause_valid = (i == 3);
         s_pause_rank  = 16'd0;
         s_pause_time  = 16'd0;
         tick(1);
      end
      s_pause_valid = 1'b0;
      m_frame_ready = 1'b1;
      wait_drain("t2_drain", 4 * MIN_GAP);
      tick(2);
      check("t2_resume_inactive", m_pause_active, 0);

      // 3: three events during the gap collapse into one frame carrying the last
      for (int i = 0; i < MIN_GAP - 10; i++)
         if (m_frame_valid) tick(1);
      check("t3_in_gap", m_frame_valid, 0);
      expect_frame(16'd3, 16'd30);
      send_event(16'd1, 16'd10);
      send_event(16'd2, 16'd20);
      send_event(16'd3, 16'd30);
`ifdef GPFC_PAUSE_STATS_EN
      check("t3_coalesced", stat_coalesced, 2);
`endif
      wait_drain("t3_drain", 4 * MIN_GAP);
      tick(2);
      check("t3_active", m_pause_active, 1);

      // 4: active pause is re-sent every REFRESH+2 cycles until a resume goes out
      idx = acc_cyc.size() - 1;
      expect_frame(16'd3, 16'd30);
      expect_frame(16'd3, 16'd30);
      wait_drain("t4_refresh_drain", 3 * REFRESH);
      check("t4_period1", acc_cyc[idx + 1] - acc_cyc[idx], REFRESH + 2);
      check("t4_period2", acc_cyc[idx + 2] - acc_cyc[idx + 1], REFRESH + 2);
      expect_frame(16'd0, 16'd0);
      send_event(16'd0, 16'd0);
      wait_drain("t4_resume_drain", 4 * MIN_GAP);
      tick(2 * REFRESH);
      check("t4_refresh_stopped", n_frames, n_pushed);
      check("t4_inactive", m_pause_active, 0);

      // 5: an event landing on the refresh expiry cycle replaces the refresh copy
      expect_frame(16'd4, 16'd500);
      send_event(16'd4, 16'd500);
      wait_drain("t5_first_drain", 4 * MIN_GAP);
      idx = acc_cyc.size() - 1;
      for (int i = 0; i < 2 * REFRESH; i++) begin
         if (cyc == acc_cyc[idx] + REFRESH) break;
         tick(1);
      end
      check("t5_align", cyc, acc_cyc[idx] + REFRESH);
      expect_frame(16'd6, 16'd77);
      send_event(16'd6, 16'd77);
      wait_drain("t5_event_drain", 4 * MIN_GAP);
      check("t5_event_timing", acc_cyc[idx + 1] - acc_cyc[idx], REFRESH + 2);
      expect_frame(16'd0, 16'd0);
      send_event(16'd0, 16'd0);
      wait_drain("t5_resume_drain", 4 * MIN_GAP);
      tick(2);
      check("t5_inactive", m_pause_active, 0);
`ifdef GPFC_PAUSE_STATS_EN
      check("stat_frames_sent", stat_frames_sent, n_pushed);
      check("stat_coalesced_total", stat_coalesced, 2);
`endif

      // 6: reset during a stalled SEND with a pending event drops both
      m_frame_ready = 1'b0;
      send_event(16'd8, 16'd88);
      wait_valid("t6_valid_timeout", 3 * MIN_GAP);
      send_event(16'd11, 16'd11);
      rstn = 1'b0;
      tick(1);
      check("t6_rst_valid", m_frame_valid, 0);
      check("t6_rst_rank", m_frame_rank, 0);
      check("t6_rst_time", m_frame_time, 0);
`ifdef GPFC_PAUSE_STATS_EN
      check("t6_rst_stat_sent", stat_frames_sent, 0);
      check("t6_rst_stat_coal", stat_coalesced, 0);
`endif
      rstn = 1'b1;
      m_frame_ready = 1'b1;
      tick(3 * MIN_GAP);
      check("t6_no_frame_after_reset", n_frames, n_pushed);
      check("t6_valid_low", m_frame_valid, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
